// File: rtl/spotlight_positioner.sv
`default_nettype none
// ============================================================================
// Module      : spotlight_positioner
// Description : Stage-side spotlight stepper driver. Filters the controller's
//               3-bit command, steps the motor to one of three positions and
//               reports the result on active-low position sensors.
// Revision    : 1.0 - initial release
// ============================================================================
module spotlight_positioner #(
    parameter int POS_W      = 8,
    parameter int LEFT_POS   = 16,
    parameter int CENTER_POS = 128,
    parameter int RIGHT_POS  = 240,
    parameter int STEP_DIV   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int SENSOR_WIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       S1,
    output logic             step,
    output logic             dir,
    output logic             lamp_on,
    output logic             busy,
    output logic             at_target,
    output logic             err,
    output logic [POS_W-1:0] pos,
    output logic             TL,
    output logic             TC,
    output logic             TR
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [SET_W-1:0] C_SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [POS_W-1:0] C_LEFT     = POS_W'(LEFT_POS);
    localparam logic [POS_W-1:0] C_CENTER   = POS_W'(CENTER_POS);
    localparam logic [POS_W-1:0] C_RIGHT    = POS_W'(RIGHT_POS);
    localparam logic [POS_W-1:0] C_WIN      = POS_W'(SENSOR_WIN);

    localparam logic C_TL_RST = (CENTER_POS - LEFT_POS) > SENSOR_WIN;
    localparam logic C_TR_RST = (RIGHT_POS - CENTER_POS) > SENSOR_WIN;

    localparam logic [2:0] C_CMD_PARK   = 3'b001;
    localparam logic [2:0] C_CMD_LEFT   = 3'b101;
    localparam logic [2:0] C_CMD_CENTER = 3'b100;
    localparam logic [2:0] C_CMD_RIGHT  = 3'b111;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_MOVE   = 2'd1;
    localparam logic [1:0] C_ST_SETTLE = 2'd2;

    logic [2:0]       s1_q, s1_d, cmd_q, cmd_d;
    logic [POS_W-1:0] target_q, target_d, pos_q, pos_d;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             dir_q, dir_d, step_q, step_d, lamp_q, lamp_d;
    logic             err_q, err_d, at_target_q, at_target_d;
    logic             tl_q, tl_d, tc_q, tc_d, tr_q, tr_d;

    logic             w_accept, w_need_right, w_at_pos, w_reverse;
    logic             w_terminal, w_stepping;
    logic [POS_W-1:0] w_pos_step;

    function automatic logic near(input logic [POS_W-1:0] p,
                                  input logic [POS_W-1:0] c);
        logic [POS_W-1:0] d;
        d = (p >= c) ? (p - c) : (c - p);
        return (d <= C_WIN);
    endfunction

    assign w_accept     = (S1 == s1_q);
    assign w_need_right = (target_q > pos_q);
    assign w_at_pos     = (target_q == pos_q);
    assign w_reverse    = (w_need_right != dir_q);
    assign w_terminal   = (div_q == C_DIV_LAST);
    // A reversal consumes the terminal count so dir gets a full divider period of setup.
    assign w_stepping   = (state_q == C_ST_MOVE) && !w_at_pos && !w_reverse && w_terminal;
    assign w_pos_step   = w_need_right ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q        <= C_CMD_PARK;
            cmd_q       <= C_CMD_PARK;
            target_q    <= C_CENTER;
            pos_q       <= C_CENTER;
            state_q     <= C_ST_IDLE;
            div_q       <= '0;
            settle_q    <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            lamp_q      <= 1'b0;
            err_q       <= 1'b0;
            at_target_q <= 1'b1;
            tl_q        <= C_TL_RST;
            tc_q        <= 1'b0;
            tr_q        <= C_TR_RST;
        end else begin
            s1_q        <= s1_d;
            cmd_q       <= cmd_d;
            target_q    <= target_d;
            pos_q       <= pos_d;
            state_q     <= state_d;
            div_q       <= div_d;
            settle_q    <= settle_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            lamp_q      <= lamp_d;
            err_q       <= err_d;
            at_target_q <= at_target_d;
            tl_q        <= tl_d;
            tc_q        <= tc_d;
            tr_q        <= tr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (!w_at_pos) state_d = C_ST_MOVE;
            end
            C_ST_MOVE: begin
                if (w_at_pos) state_d = C_ST_SETTLE;
                else if (w_stepping && (w_pos_step == target_q)) state_d = C_ST_SETTLE;
            end
            C_ST_SETTLE: begin
                if (!w_at_pos) state_d = C_ST_MOVE;
                else if (settle_q == C_SET_LAST) state_d = C_ST_IDLE;
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        pos_d       = w_stepping ? w_pos_step : pos_q;
        step_d      = w_stepping;
        dir_d       = w_at_pos ? dir_q : w_need_right;
        div_d       = '0;
        if ((state_q == C_ST_MOVE) && !w_reverse && !w_terminal) div_d = div_q + DIV_W'(1);
        settle_d    = (state_q == C_ST_SETTLE) ? (settle_q + SET_W'(1)) : '0;
        at_target_d = (state_d == C_ST_IDLE);
        busy        = (state_q != C_ST_IDLE);
        tl_d        = !near(pos_d, C_LEFT);
        tc_d        = !near(pos_d, C_CENTER);
        tr_d        = !near(pos_d, C_RIGHT);
    end

    // An illegal code pins the target to the next position, halting the motor in place.
    always_comb begin
        s1_d     = S1;
        cmd_d    = cmd_q;
        target_d = target_q;
        err_d    = err_q;
        lamp_d   = lamp_q;
        if (w_accept) begin
            cmd_d = S1;
            err_d = 1'b0;
            case (S1)
                C_CMD_PARK, C_CMD_CENTER: target_d = C_CENTER;
                C_CMD_LEFT:               target_d = C_LEFT;
                C_CMD_RIGHT:              target_d = C_RIGHT;
                default: begin
                    err_d    = 1'b1;
                    target_d = pos_d;
                end
            endcase
        end
        if ((state_q == C_ST_IDLE) && (state_d == C_ST_MOVE)) lamp_d = 1'b0;
        if ((state_q == C_ST_SETTLE) && (state_d == C_ST_IDLE))
            lamp_d = (cmd_d == C_CMD_LEFT) || (cmd_d == C_CMD_CENTER) || (cmd_d == C_CMD_RIGHT);
        if (w_accept && ((S1 == C_CMD_PARK) || err_d)) lamp_d = 1'b0;
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign lamp_on   = lamp_q;
    assign at_target = at_target_q;
    assign err       = err_q;
    assign pos       = pos_q;
    assign TL        = tl_q;
    assign TC        = tc_q;
    assign TR        = tr_q;

endmodule
`default_nettype wire

// File: tb/tb_spotlight_positioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_spotlight_positioner
// Description : Scoreboard bench for spotlight_positioner; expected step
//               positions are queued by a position-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spotlight_positioner;

    localparam int STEP_DIV   = 4;
    localparam int SETTLE_CYC = 8;
    localparam int LEFT       = 16;
    localparam int CENTER     = 128;
    localparam int RIGHT      = 240;
    localparam int WIN        = 2;
    localparam int FIRST_GAP  = 3 + STEP_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] S1 = 3'b001;
    logic       step, dir, lamp_on, busy, at_target, err, TL, TC, TR;
    logic [7:0] pos;

    spotlight_positioner #(
        .POS_W(8), .LEFT_POS(LEFT), .CENTER_POS(CENTER), .RIGHT_POS(RIGHT),
        .STEP_DIV(STEP_DIV), .SETTLE_CYC(SETTLE_CYC), .SENSOR_WIN(WIN)
    ) dut (
        .clk(clk), .reset(reset), .S1(S1), .step(step), .dir(dir),
        .lamp_on(lamp_on), .busy(busy), .at_target(at_target), .err(err),
        .pos(pos), .TL(TL), .TC(TC), .TR(TR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pos;
        bit dir;
        int gap;
    } step_t;

    step_t exp_q[$];
    int    n_vec = 0, n_err = 0;
    int    last_evt = 0, last_step = 0, at_rise = 0, step_total = 0;
    bit    prev_at = 1'b1;
    int    model_pos = CENTER;
    bit    model_lamp = 1'b0, model_err = 1'b0;

    function automatic bit sens(input int p, input int c);
        int d;
        d = (p > c) ? p - c : c - p;
        return !(d <= WIN);
    endfunction

    function automatic int tgt(input logic [2:0] c);
        case (c)
            3'b101:         return LEFT;
            3'b100, 3'b001: return CENTER;
            3'b111:         return RIGHT;
            default:        return -1;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: each step pulse pops one expected position off the scoreboard.
    initial begin
        step_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (step) begin
                    step_total++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL step_unexpected: pos=%0d dir=%0d, required no step", pos, dir);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(pos) != e.pos || dir != e.dir || TL != sens(e.pos, LEFT) ||
                            TC != sens(e.pos, CENTER) || TR != sens(e.pos, RIGHT)) begin
                            n_err++;
                            $display("FAIL step: pos=%0d dir=%0d TL/TC/TR=%b%b%b, required pos=%0d dir=%0d TL/TC/TR=%b%b%b",
                                     pos, dir, TL, TC, TR, e.pos, e.dir,
                                     sens(e.pos, LEFT), sens(e.pos, CENTER), sens(e.pos, RIGHT));
                        end
                        if (e.gap > 0) begin
                            n_vec++;
                            if (cyc - last_evt != e.gap) begin
                                n_err++;
                                $display("FAIL step_gap at pos %0d: got %0d cycles, required %0d",
                                         e.pos, cyc - last_evt, e.gap);
                            end
                        end
                    end
                    last_evt  = cyc;
                    last_step = cyc;
                end
                if (at_target && !prev_at) at_rise = cyc;
            end
            prev_at = at_target;
        end
    end

    task automatic push_move(input int from, input int to, input int first_gap);
        int p;
        bit d;
        p = from;
        d = (to > from);
        while (p != to) begin
            p = d ? p + 1 : p - 1;
            exp_q.push_back('{pos: p, dir: d, gap: (p == (d ? from + 1 : from - 1)) ? first_gap : STEP_DIV});
        end
    endtask

    task automatic apply(input logic [2:0] cmd);
        @(negedge clk);
        S1 = cmd;
        last_evt = cyc;
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (int'(pos) != p && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos_reached", int'(pos), p);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic check_idle(input bit moved, input int s0, input int nsteps);
        check("pos", int'(pos), model_pos);
        check("at_target", int'(at_target), 1);
        check("lamp_on", int'(lamp_on), int'(model_lamp));
        check("err", int'(err), int'(model_err));
        check("sensors", int'({TL, TC, TR}),
              int'({sens(model_pos, LEFT), sens(model_pos, CENTER), sens(model_pos, RIGHT)}));
        check("step_count", step_total - s0, nsteps);
        check("queue_drained", exp_q.size(), 0);
        if (moved) check("settle_time", at_rise - last_step, SETTLE_CYC);
    endtask

    task automatic go(input logic [2:0] cmd, input bit glitch);
        int t, from, s0;
        bit moved;
        logic [2:0] g;
        t     = tgt(cmd);
        from  = model_pos;
        moved = (t != from);
        if (moved) begin
            push_move(from, t, FIRST_GAP);
            model_lamp = (cmd != 3'b001);
        end else if (cmd == 3'b001) begin
            model_lamp = 1'b0;
        end
        model_err = 1'b0;
        s0 = step_total;
        if (glitch) begin
            g = 3'($urandom_range(0, 7));
            while (g == cmd || g == S1) g = g + 3'd1;
            @(negedge clk);
            S1 = g;
        end
        apply(cmd);
        wait_idle();
        model_pos = t;
        check_idle(moved, s0, moved ? ((t > from) ? t - from : from - t) : 0);
    endtask

    initial begin
        int s0, x, busy_seen;
        logic [2:0] cmds [4];
        cmds = '{3'b001, 3'b101, 3'b100, 3'b111};

        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset release with park held
        @(negedge clk);
        check("rst_pos", int'(pos), CENTER);
        check("rst_sensors", int'({TL, TC, TR}), int'(3'b101));
        check("rst_at_target", int'(at_target), 1);
        check("rst_lamp", int'(lamp_on), 0);
        check("rst_err", int'(err), 0);
        repeat (100) @(negedge clk);
        check("rst_no_steps", step_total, 0);
        check("rst_pos_hold", int'(pos), CENTER);

        // Single-cycle glitch never accepted
        @(negedge clk); S1 = 3'b101;
        @(negedge clk); S1 = 3'b100;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("glitch_busy", busy_seen, 0);
        check("glitch_pos", int'(pos), CENTER);
        check("glitch_lamp", int'(lamp_on), 0);

        // Full move right and back
        go(3'b111, 1'b0);
        go(3'b100, 1'b0);

        // Reversal mid-move at 150
        push_move(CENTER, 150, FIRST_GAP);
        s0 = step_total;
        apply(3'b111);
        wait_pos(150);
        S1 = 3'b101;
        push_move(150, LEFT, FIRST_GAP);
        repeat (2) @(negedge clk);
        check("rev_dir_before", int'(dir), 1);
        @(negedge clk);
        check("rev_dir_after", int'(dir), 0);
        wait_idle();
        model_pos  = LEFT;
        model_lamp = 1'b1;
        model_err  = 1'b0;
        check_idle(1'b1, s0, 22 + 134);
        go(3'b100, 1'b0);

        // Illegal code during a move
        x = $urandom_range(131, 200);
        push_move(CENTER, x, FIRST_GAP);
        s0 = step_total;
        apply(3'b111);
        wait_pos(x);
        S1 = 3'b010;
        model_pos  = x;
        model_lamp = 1'b0;
        model_err  = 1'b1;
        wait_idle();
        check_idle(1'b0, s0, x - CENTER);
        repeat (20) @(negedge clk);
        check("illegal_pos_hold", int'(pos), x);
        go(3'b100, 1'b0);

        // Randomised legal commands, some preceded by a one-cycle glitch
        for (int i = 0; i < 8; i++) begin
            go(cmds[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a move
        go(3'b100, 1'b0);
        push_move(CENTER, 135, FIRST_GAP);
        apply(3'b111);
        wait_pos(135);
        #2;
        reset = 1'b0;
        S1    = 3'b001;
        #1;
        check("arst_pos", int'(pos), CENTER);
        check("arst_step", int'(step), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_at_target", int'(at_target), 1);
        check("arst_lamp", int'(lamp_on), 0);
        check("arst_err", int'(err), 0);
        check("arst_dir", int'(dir), 0);
        check("arst_sensors", int'({TL, TC, TR}), int'(3'b101));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        s0 = step_total;
        repeat (30) @(negedge clk);
        model_pos  = CENTER;
        model_lamp = 1'b0;
        model_err  = 1'b0;
        check_idle(1'b0, s0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
